// File: rtl/tl_sched.sv
// ----------------------------------------------------------------------------
// tl_sched -- timed two-road traffic-light scheduler with pedestrian phase.
//
// Sequences the road A / road B signal heads from traffic sensors Ta/Tb and a
// latched pedestrian request. Each green is held for at least GREEN_MIN
// cycles. Once the other side is waiting, a green ends at GREEN_MAX cycles,
// or earlier if its own road is empty. Yellow lasts YELLOW_T cycles. A walk
// phase with both roads red lasts WALK_T cycles.
//
// Optional feature macro: ALL_RED_EN
//   defined   : yellow is followed by an all-red clearance phase (AR/BR) of
//               ALLRED_T cycles. The walk/green decision moves to its exit.
//   undefined : yellow exits directly to WALK or the opposite green.
//
// Light encoding: 2'b00 green, 2'b01 yellow, 2'b10 red.
// All outputs are registered and are decoded from the next state, so the
// outputs always match the state register. No input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module tl_sched #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int WALK_T    = 3,
`ifdef ALL_RED_EN
    parameter int ALLRED_T  = 1,
`endif
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       ped_walk
);

    typedef enum logic [2:0] {
        S_AG   = 3'd0,
        S_AY   = 3'd1,
        S_BG   = 3'd2,
        S_BY   = 3'd3,
        S_WALK = 3'd4
`ifdef ALL_RED_EN
        ,
        S_AR   = 3'd5,
        S_BR   = 3'd6
`endif
    } state_t;

    // Phase-timer thresholds, stored as "last cycle index" values.
    localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] C_WALK = CNT_W'(WALK_T - 1);
`ifdef ALL_RED_EN
    localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALLRED_T - 1);
`endif
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);

    // Light pattern {La, Lb, ped_walk} for a state. Unknown encodings show
    // all red as the safe fallback.
    function automatic logic [4:0] f_lights(input state_t s);
        logic [4:0] v;
        case (s)
            S_AG:    v = {2'b00, 2'b10, 1'b0};
            S_AY:    v = {2'b01, 2'b10, 1'b0};
            S_BG:    v = {2'b10, 2'b00, 1'b0};
            S_BY:    v = {2'b10, 2'b01, 1'b0};
            S_WALK:  v = {2'b10, 2'b10, 1'b1};
            default: v = {2'b10, 2'b10, 1'b0};
        endcase
        return v;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_ped_pend;
    logic             r_next_b;
    logic [4:0]       r_lights;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_pend_now;
    logic             w_pend_nxt;
    logic             w_next_b_nxt;
    logic             w_go_a;
    logic             w_go_b;

    // The pending request seen at a decision point includes this cycle's button press.
    always_comb begin
        w_pend_now = r_ped_pend;
        if (r_state != S_WALK) begin
            w_pend_now = r_ped_pend | ped_req;
        end else begin
            w_pend_now = r_ped_pend;
        end
    end

    // Green-exit conditions. Each green ends only if someone else is waiting.
    always_comb begin
        w_go_a = (r_timer >= C_GMIN) && (Tb | w_pend_now) &&
                 (!Ta || (r_timer >= C_GMAX));
        w_go_b = (r_timer >= C_GMIN) && (Ta | w_pend_now) &&
                 (!Tb || (r_timer >= C_GMAX));
    end

    // Next-state logic. Green exit and yellow (or all-red) exit are the only decision points.
    always_comb begin
        w_state_nxt  = r_state;
        w_next_b_nxt = r_next_b;
        case (r_state)
            S_AG: begin
                if (w_go_a) begin
                    w_state_nxt = S_AY;
                end else begin
                    w_state_nxt = S_AG;
                end
            end
            S_BG: begin
                if (w_go_b) begin
                    w_state_nxt = S_BY;
                end else begin
                    w_state_nxt = S_BG;
                end
            end
`ifdef ALL_RED_EN
            S_AY: begin
                if (r_timer == C_YEL) begin
                    w_state_nxt = S_AR;
                end else begin
                    w_state_nxt = S_AY;
                end
            end
            S_BY: begin
                if (r_timer == C_YEL) begin
                    w_state_nxt = S_BR;
                end else begin
                    w_state_nxt = S_BY;
                end
            end
            S_AR: begin
                if ((r_timer == C_AR) && w_pend_now) begin
                    w_state_nxt  = S_WALK;
                    w_next_b_nxt = 1'b1;
                end else if (r_timer == C_AR) begin
                    w_state_nxt  = S_BG;
                end else begin
                    w_state_nxt  = S_AR;
                end
            end
            S_BR: begin
                if ((r_timer == C_AR) && w_pend_now) begin
                    w_state_nxt  = S_WALK;
                    w_next_b_nxt = 1'b0;
                end else if (r_timer == C_AR) begin
                    w_state_nxt  = S_AG;
                end else begin
                    w_state_nxt  = S_BR;
                end
            end
`else
            S_AY: begin
                if ((r_timer == C_YEL) && w_pend_now) begin
                    w_state_nxt  = S_WALK;
                    w_next_b_nxt = 1'b1;
                end else if (r_timer == C_YEL) begin
                    w_state_nxt  = S_BG;
                end else begin
                    w_state_nxt  = S_AY;
                end
            end
            S_BY: begin
                if ((r_timer == C_YEL) && w_pend_now) begin
                    w_state_nxt  = S_WALK;
                    w_next_b_nxt = 1'b0;
                end else if (r_timer == C_YEL) begin
                    w_state_nxt  = S_AG;
                end else begin
                    w_state_nxt  = S_BY;
                end
            end
`endif
            S_WALK: begin
                if ((r_timer == C_WALK) && r_next_b) begin
                    w_state_nxt = S_BG;
                end else if (r_timer == C_WALK) begin
                    w_state_nxt = S_AG;
                end else begin
                    w_state_nxt = S_WALK;
                end
            end
            default: begin
                w_state_nxt  = S_AG;
                w_next_b_nxt = 1'b0;
            end
        endcase
    end

    // Phase timer restarts on every state change and saturates at the green maximum.
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = C_ZERO;
        end else if (r_timer < C_GMAX) begin
            w_timer_nxt = r_timer + C_ONE;
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    // The pedestrian latch clears on WALK entry. Otherwise it keeps any request seen outside WALK.
    always_comb begin
        w_pend_nxt = w_pend_now;
        if ((w_state_nxt == S_WALK) && (r_state != S_WALK)) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = w_pend_now;
        end
    end

    // State, timer and request registers. The output register is loaded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_AG;
            r_timer    <= C_ZERO;
            r_ped_pend <= 1'b0;
            r_next_b   <= 1'b0;
            r_lights   <= f_lights(S_AG);
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_ped_pend <= w_pend_nxt;
            r_next_b   <= w_next_b_nxt;
            r_lights   <= f_lights(w_state_nxt);
        end
    end

    assign La       = r_lights[4:3];
    assign Lb       = r_lights[2:1];
    assign ped_walk = r_lights[0];

endmodule
